// File: rtl/actuador_alarma.sv
// rtl/actuador_alarma.sv - actuator driver: buzzer beep cadence, fan PWM with run-on, blinking warning LED.
// Optional ALARM_ESCALATE_EN: a silenced alarm re-arms after ESC_MS ticks while the request persists.
module actuador_alarma #(
  parameter int TICK_DIV    = 50000,
  parameter int BEEP_ON_MS  = 200,
  parameter int BEEP_OFF_MS = 300,
  parameter int BLINK_MS    = 500,
  parameter int FAN_HOLD_MS = 2000,
  parameter int PWM_BITS    = 4,
  parameter int FAN_DUTY    = 12,
  parameter int ESC_MS      = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       actala,
  input  logic       actvent,
  input  logic       actavis,
  input  logic       ack,
  output logic       buzzer,
  output logic       fan_pwm,
  output logic       led,
  output logic [1:0] estado
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXMS = imax(imax(imax(BEEP_ON_MS, BEEP_OFF_MS), imax(BLINK_MS, FAN_HOLD_MS)), ESC_MS);
  localparam int CW    = (MAXMS > 1) ? $clog2(MAXMS + 1) : 1;
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0]       TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]       ON_LAST    = CW'(BEEP_ON_MS - 1);
  localparam logic [CW-1:0]       OFF_LAST   = CW'(BEEP_OFF_MS - 1);
  localparam logic [CW-1:0]       BLINK_LAST = CW'(BLINK_MS - 1);
  localparam logic [CW-1:0]       HOLD_INIT  = CW'(FAN_HOLD_MS);
  localparam logic [PWM_BITS-1:0] DUTY       = PWM_BITS'(FAN_DUTY);
`ifdef ALARM_ESCALATE_EN
  localparam logic [CW-1:0]       ESC_LAST   = CW'(ESC_MS - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_BEEP_ON  = 2'b01,
    S_BEEP_OFF = 2'b10,
    S_SILENCED = 2'b11
  } state_t;

  logic en_r, ala_r, vent_r, avis_r, ack_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_r   <= 1'b0;
      ala_r  <= 1'b0;
      vent_r <= 1'b0;
      avis_r <= 1'b0;
      ack_r  <= 1'b0;
    end else begin
      en_r   <= en;
      ala_r  <= actala;
      vent_r <= actvent;
      avis_r <= actavis;
      ack_r  <= ack;
    end
  end

  // 1 ms time base, restarted from zero whenever the system is re-enabled
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = en_r && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (!en_r || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  state_t        state;
  logic [CW-1:0] phase;
`ifdef ALARM_ESCALATE_EN
  logic [CW-1:0] esc;
`endif

  assign estado = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      phase  <= '0;
      buzzer <= 1'b0;
`ifdef ALARM_ESCALATE_EN
      esc    <= '0;
`endif
    end else if (!en_r) begin
      state  <= S_IDLE;
      phase  <= '0;
      buzzer <= 1'b0;
`ifdef ALARM_ESCALATE_EN
      esc    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ala_r) begin
            state  <= S_BEEP_ON;
            phase  <= '0;
            buzzer <= 1'b1;
          end
        end
        S_BEEP_ON: begin
          // request drop outranks acknowledge, which outranks the cadence
          if (!ala_r) begin
            state  <= S_IDLE;
            phase  <= '0;
            buzzer <= 1'b0;
          end else if (ack_r) begin
            state  <= S_SILENCED;
            phase  <= '0;
            buzzer <= 1'b0;
          end else if (tick) begin
            if (phase == ON_LAST) begin
              state  <= S_BEEP_OFF;
              phase  <= '0;
              buzzer <= 1'b0;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        S_BEEP_OFF: begin
          if (!ala_r) begin
            state  <= S_IDLE;
            phase  <= '0;
            buzzer <= 1'b0;
          end else if (ack_r) begin
            state  <= S_SILENCED;
            phase  <= '0;
            buzzer <= 1'b0;
          end else if (tick) begin
            if (phase == OFF_LAST) begin
              state  <= S_BEEP_ON;
              phase  <= '0;
              buzzer <= 1'b1;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        S_SILENCED: begin
          if (!ala_r) begin
            state  <= S_IDLE;
`ifdef ALARM_ESCALATE_EN
            esc    <= '0;
          end else if (tick) begin
            if (esc == ESC_LAST) begin
              state  <= S_BEEP_ON;
              phase  <= '0;
              esc    <= '0;
              buzzer <= 1'b1;
            end else begin
              esc <= esc + 1'b1;
            end
`endif
          end
        end
        default: begin
          state  <= S_IDLE;
          phase  <= '0;
          buzzer <= 1'b0;
        end
      endcase
    end
  end

  logic [CW-1:0]       hold, hold_n;
  logic                fan_act_q, act_n;
  logic [PWM_BITS-1:0] pwm_cnt, pwm_n;

  // fan_act_q is the previous activity, so a fresh run always starts at PWM slot 0
  always_comb begin
    hold_n = hold;
    if (vent_r) begin
      hold_n = HOLD_INIT;
    end else if (tick && (hold != '0)) begin
      hold_n = hold - 1'b1;
    end
    act_n = vent_r | (hold_n != '0);
    pwm_n = fan_act_q ? pwm_cnt + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      fan_act_q <= 1'b0;
      pwm_cnt   <= '0;
      fan_pwm   <= 1'b0;
    end else if (!en_r) begin
      hold      <= '0;
      fan_act_q <= 1'b0;
      pwm_cnt   <= '0;
      fan_pwm   <= 1'b0;
    end else begin
      hold      <= hold_n;
      fan_act_q <= act_n;
      pwm_cnt   <= act_n ? pwm_n : '0;
      fan_pwm   <= act_n & (pwm_n < DUTY);
    end
  end

  logic          avis_d;
  logic [CW-1:0] blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avis_d <= 1'b0;
      blink  <= '0;
      led    <= 1'b0;
    end else if (!en_r || !avis_r) begin
      avis_d <= 1'b0;
      blink  <= '0;
      led    <= 1'b0;
    end else begin
      avis_d <= 1'b1;
      if (!avis_d) begin
        blink <= '0;
        led   <= 1'b1;
      end else if (tick) begin
        if (blink == BLINK_LAST) begin
          blink <= '0;
          led   <= ~led;
        end else begin
          blink <= blink + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_actuador_alarma.sv
// tb/tb_actuador_alarma.sv - randomized scoreboard bench for actuador_alarma against a cadence-arithmetic model.
module tb_actuador_alarma;

  localparam int TICK_DIV = 4;
  localparam int ON       = 3;
  localparam int OFF      = 2;
  localparam int BLINK    = 2;
  localparam int HOLD     = 5;
  localparam int PWM_BITS = 2;
  localparam int DUTY     = 3;
  localparam int ESC      = 6;

  localparam int A_IDLE = 0;
  localparam int A_BEEP = 1;
  localparam int A_SIL  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       actala = 1'b0;
  logic       actvent = 1'b0;
  logic       actavis = 1'b0;
  logic       ack = 1'b0;
  logic       buzzer, fan_pwm, led;
  logic [1:0] estado;

  always #5 clk = ~clk;

  actuador_alarma #(
    .TICK_DIV(TICK_DIV), .BEEP_ON_MS(ON), .BEEP_OFF_MS(OFF), .BLINK_MS(BLINK),
    .FAN_HOLD_MS(HOLD), .PWM_BITS(PWM_BITS), .FAN_DUTY(DUTY), .ESC_MS(ESC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .actala(actala), .actvent(actvent),
    .actavis(actavis), .ack(ack), .buzzer(buzzer), .fan_pwm(fan_pwm),
    .led(led), .estado(estado)
  );

  logic [4:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pushes = 0;

  // Reference model: ticks every TICK_DIV cycles of enable; cadences from tick counts since each event.
  bit m_en, m_ala, m_vent, m_avis, m_ack;
  int run, tcount, amode, a_t0, l_t0, drop_ticks, act_len;
  bit led_on;
`ifdef ALARM_ESCALATE_EN
  int s_t0;
`endif

  initial begin
    bit         tick_now, fan_e, led_e, active;
    logic [1:0] st_e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_en = 0; m_ala = 0; m_vent = 0; m_avis = 0; m_ack = 0;
        run = 0; tcount = 0; amode = A_IDLE; a_t0 = 0; l_t0 = 0;
        drop_ticks = HOLD; act_len = 0; led_on = 0;
        exp_q.push_back(5'b0);
      end else begin
        tick_now = 0;
        if (m_en) begin
          run++;
          tick_now = (run % TICK_DIV == 0);
        end else begin
          run = 0;
        end
        if (tick_now) tcount++;

        if (!m_en) amode = A_IDLE;
        else begin
          case (amode)
            A_IDLE: if (m_ala) begin amode = A_BEEP; a_t0 = tcount; end
            A_BEEP: begin
              if (!m_ala) amode = A_IDLE;
              else if (m_ack) begin
                amode = A_SIL;
`ifdef ALARM_ESCALATE_EN
                s_t0 = tcount;
`endif
              end
            end
            default: begin
              if (!m_ala) amode = A_IDLE;
`ifdef ALARM_ESCALATE_EN
              else if (tick_now && (tcount - s_t0 == ESC)) begin amode = A_BEEP; a_t0 = tcount; end
`endif
            end
          endcase
        end
        if (amode == A_IDLE) st_e = 2'b00;
        else if (amode == A_SIL) st_e = 2'b11;
        else st_e = (((tcount - a_t0) % (ON + OFF)) < ON) ? 2'b01 : 2'b10;

        if (!m_en) begin
          drop_ticks = HOLD; act_len = 0; fan_e = 0;
        end else begin
          if (m_vent) drop_ticks = 0;
          else if (tick_now && drop_ticks < HOLD) drop_ticks++;
          active = m_vent || (drop_ticks < HOLD);
          if (active) begin
            fan_e = ((act_len % (1 << PWM_BITS)) < DUTY);
            act_len++;
          end else begin
            fan_e = 0; act_len = 0;
          end
        end

        if (!m_en || !m_avis) begin
          led_e = 0; led_on = 0;
        end else if (!led_on) begin
          led_on = 1; l_t0 = tcount; led_e = 1;
        end else begin
          led_e = (((tcount - l_t0) / BLINK) % 2) == 0;
        end

        exp_q.push_back({st_e, (st_e == 2'b01), fan_e, led_e});
        m_en = en; m_ala = actala; m_vent = actvent; m_avis = actavis; m_ack = ack;
      end
      pushes++;
    end
  end

  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        if (pushes > 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_underflow t=%0t no expected entry", $time);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({estado, buzzer, fan_pwm, led} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got estado=%b buzzer=%b fan_pwm=%b led=%b expected estado=%b buzzer=%b fan_pwm=%b led=%b",
                   $time, estado, buzzer, fan_pwm, led, e[4:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  int r_en = 0, r_ala = 0, r_vent = 0, r_avis = 0;

  task automatic drive_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (r_en == 0) begin
        en = ~en;
        r_en = en ? int'($urandom_range(150, 500)) : int'($urandom_range(1, 6));
      end else r_en--;
      if (r_ala == 0) begin actala = ~actala; r_ala = $urandom_range(10, 90); end else r_ala--;
      if (r_vent == 0) begin actvent = ~actvent; r_vent = $urandom_range(1, 50); end else r_vent--;
      if (r_avis == 0) begin actavis = ~actavis; r_avis = $urandom_range(1, 60); end else r_avis--;
      ack = ($urandom_range(0, 19) == 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_estado", int'(estado), 0);
    chk("reset_buzzer", int'(buzzer), 0);
    chk("reset_fan_pwm", int'(fan_pwm), 0);
    chk("reset_led", int'(led), 0);
    rst_n = 1'b1;
    drive_random(1500);

    @(negedge clk);
    en = 1'b1; actala = 1'b0; ack = 1'b0; actvent = 1'b1; actavis = 1'b1;
    repeat (4) @(negedge clk);
    actala = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_reset_buzzer", int'(buzzer), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_estado", int'(estado), 0);
    chk("async_reset_buzzer", int'(buzzer), 0);
    chk("async_reset_fan_pwm", int'(fan_pwm), 0);
    chk("async_reset_led", int'(led), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r_en = 200;
    drive_random(1500);

    @(negedge clk);
    actala = 1'b0; actvent = 1'b0; actavis = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
